// File: rtl/fetch_sequencer.sv
// fetch_sequencer: front-end PC sequencer with a BOOT/RUN/FLUSH state machine.
// Picks the next fetch address from mispredict redirect, hazard stall,
// branch prediction or sequential PC+4. After a redirect it inserts
// FLUSH_CYCLES bubble cycles at the new PC.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        synchronous reset, active low
//   stall_i        hold the PC (hazard)
//   br_pred_i      current fetch predicted taken
//   pred_pc_i      predicted target
//   br_sig_i       branch/jump resolved in execute
//   miss_pred_i    resolved branch mispredicted (qualified by br_sig_i)
//   correct_pc_i   correct next PC on a mispredict
//   pc_o           current fetch address
//   fetch_valid_o  pc_o is a real fetch
//   flush_o        kill younger instructions in IF/ID (combinational)
//
// Optional feature: define FETCH_SEQ_STATS_EN to add saturating statistics
// outputs br_count_o (cycles with br_sig_i) and miss_count_o (redirect cycles).
module fetch_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall_i,
   input  logic        br_pred_i,
   input  logic [31:0] pred_pc_i,
   input  logic        br_sig_i,
   input  logic        miss_pred_i,
   input  logic [31:0] correct_pc_i,
   output logic [31:0] pc_o,
   output logic        fetch_valid_o,
   output logic        flush_o
`ifdef FETCH_SEQ_STATS_EN
   ,
   output logic [31:0] br_count_o,
   output logic [31:0] miss_count_o
`endif
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_e;

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
   localparam logic       HAS_FLUSH  = (FLUSH_CYCLES != 0);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        redirect;

   assign redirect = br_sig_i & miss_pred_i;
   assign pc_o     = pc_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_VECTOR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      cnt_d         = cnt_q;
      fetch_valid_o = 1'b0;
      flush_o       = 1'b0;
      case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            flush_o       = redirect;
            fetch_valid_o = ~stall_i;
            if (redirect) begin
               pc_d = correct_pc_i;
               if (HAS_FLUSH) begin
                  state_d = FLUSH;
                  cnt_d   = FLUSH_LOAD;
               end
            end else if (stall_i) begin
               pc_d = pc_q;
            end else if (br_pred_i) begin
               pc_d = pred_pc_i;
            end else begin
               pc_d = pc_q + 32'd4;
            end
         end
         FLUSH: begin
            flush_o = redirect;
            if (redirect) begin
               pc_d  = correct_pc_i;
               cnt_d = FLUSH_LOAD;
            end else begin
               cnt_d = cnt_q - 3'd1;
               // Exit on the last bubble; <= also recovers from a stray zero.
               if (cnt_q <= 3'd1) begin
                  state_d = RUN;
               end
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
      // Outputs are quiet while reset is held, whatever state is present.
      if (!reset_n) begin
         fetch_valid_o = 1'b0;
         flush_o       = 1'b0;
      end
   end

`ifdef FETCH_SEQ_STATS_EN
   logic [31:0] br_count_q, miss_count_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         br_count_q   <= '0;
         miss_count_q <= '0;
      end else begin
         if (br_sig_i && (br_count_q != '1)) begin
            br_count_q <= br_count_q + 32'd1;
         end
         if (redirect && (miss_count_q != '1)) begin
            miss_count_q <= miss_count_q + 32'd1;
         end
      end
   end

   assign br_count_o   = br_count_q;
   assign miss_count_o = miss_count_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed-vector bench for fetch_sequencer with
// hand-computed expected PC, valid and flush values per cycle.
// Statistics checks are included when FETCH_SEQ_STATS_EN is defined.
module tb_fetch_sequencer;

   logic        clk;
   logic        reset_n;
   logic        stall_i;
   logic        br_pred_i;
   logic [31:0] pred_pc_i;
   logic        br_sig_i;
   logic        miss_pred_i;
   logic [31:0] correct_pc_i;
   logic [31:0] pc_o;
   logic        fetch_valid_o;
   logic        flush_o;
`ifdef FETCH_SEQ_STATS_EN
   logic [31:0] br_count_o;
   logic [31:0] miss_count_o;
`endif

   int unsigned n_checks;
   int unsigned n_errors;

   fetch_sequencer #(
      .RESET_VECTOR (32'h0000_0000),
      .FLUSH_CYCLES (2)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .stall_i       (stall_i),
      .br_pred_i     (br_pred_i),
      .pred_pc_i     (pred_pc_i),
      .br_sig_i      (br_sig_i),
      .miss_pred_i   (miss_pred_i),
      .correct_pc_i  (correct_pc_i),
      .pc_o          (pc_o),
      .fetch_valid_o (fetch_valid_o),
      .flush_o       (flush_o)
`ifdef FETCH_SEQ_STATS_EN
      ,
      .br_count_o    (br_count_o),
      .miss_count_o  (miss_count_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance one clock; return 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic stall, input logic pred, input logic [31:0] ppc,
                        input logic br, input logic miss, input logic [31:0] cpc);
      stall_i      = stall;
      br_pred_i    = pred;
      pred_pc_i    = ppc;
      br_sig_i     = br;
      miss_pred_i  = miss;
      correct_pc_i = cpc;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   // Let combinational outputs settle, then compare all three.
   task automatic expect_out(input string tag, input logic [31:0] pc,
                             input logic valid, input logic flush);
      #1;
      check_eq({tag, ".pc"},    pc_o,                   pc);
      check_eq({tag, ".valid"}, {31'd0, fetch_valid_o}, {31'd0, valid});
      check_eq({tag, ".flush"}, {31'd0, flush_o},       {31'd0, flush});
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset_n  = 1'b0;
      idle();

      // Reset with noisy inputs: outputs must stay quiet.
      step();
      drive(1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 32'h999);
      step();
      expect_out("reset", 32'h0, 1'b0, 1'b0);

      // Release: BOOT for one cycle, then free-run.
      idle();
      reset_n = 1'b1;
      expect_out("boot", 32'h0, 1'b0, 1'b0);
      step(); expect_out("run0", 32'h0, 1'b1, 1'b0);
      step(); expect_out("run4", 32'h4, 1'b1, 1'b0);
      step(); expect_out("run8", 32'h8, 1'b1, 1'b0);

      // Predicted taken at pc 8.
      drive(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
      step(); idle(); expect_out("pred40", 32'h40, 1'b1, 1'b0);
      step(); expect_out("seq44", 32'h44, 1'b1, 1'b0);

      // Stall holds the PC and suppresses valid.
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      expect_out("stall", 32'h44, 1'b0, 1'b0);
      step(); idle(); expect_out("unstall", 32'h44, 1'b1, 1'b0);
      step(); expect_out("seq48", 32'h48, 1'b1, 1'b0);

      // Mispredict to 0x100: two bubbles then fetch resumes.
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100);
      expect_out("mp_flush", 32'h48, 1'b1, 1'b1);
      step(); idle(); expect_out("mp_bub1", 32'h100, 1'b0, 1'b0);
      step(); expect_out("mp_bub2", 32'h100, 1'b0, 1'b0);
      step(); expect_out("mp_res", 32'h100, 1'b1, 1'b0);
      step(); expect_out("mp_seq", 32'h104, 1'b1, 1'b0);

      // Redirect beats simultaneous stall and prediction.
      drive(1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 32'h180);
      expect_out("prio_flush", 32'h104, 1'b0, 1'b1);
      step();
      // Second redirect in the first FLUSH cycle reloads the counter.
      drive(1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 32'h200);
      expect_out("prio_pc", 32'h180, 1'b0, 1'b1);
      step(); idle(); expect_out("re_bub1", 32'h200, 1'b0, 1'b0);
      step(); expect_out("re_bub2", 32'h200, 1'b0, 1'b0);
      step(); expect_out("re_res", 32'h200, 1'b1, 1'b0);
      step(); expect_out("re_seq", 32'h204, 1'b1, 1'b0);

      // miss_pred_i without br_sig_i is ignored.
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h300);
      expect_out("nobr_miss", 32'h204, 1'b1, 1'b0);
      step();
      // Correctly predicted branch: no flush.
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h300);
      expect_out("br_ok", 32'h208, 1'b1, 1'b0);
      step(); idle(); expect_out("br_ok_seq", 32'h20C, 1'b1, 1'b0);

      // Wrap-around from 0xFFFF_FFFC.
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC);
      step(); idle();
      step();
      step(); expect_out("wrap_top", 32'hFFFF_FFFC, 1'b1, 1'b0);
      step(); expect_out("wrap_zero", 32'h0, 1'b1, 1'b0);

      // Reset in the middle of a FLUSH abandons it.
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h500);
      step(); idle();
      expect_out("midflush", 32'h500, 1'b0, 1'b0);
      reset_n = 1'b0;
      step(); expect_out("midrst", 32'h0, 1'b0, 1'b0);
      reset_n = 1'b1;
      step(); expect_out("post_run0", 32'h0, 1'b1, 1'b0);
      step(); expect_out("post_run4", 32'h4, 1'b1, 1'b0);

`ifdef FETCH_SEQ_STATS_EN
      check_eq("stats_br0",   br_count_o,   32'd0);
      check_eq("stats_miss0", miss_count_o, 32'd0);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      step();
      step();
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h600);
      step(); idle();
      #1;
      check_eq("stats_br3",   br_count_o,   32'd3);
      check_eq("stats_miss1", miss_count_o, 32'd1);
      reset_n = 1'b0;
      step();
      check_eq("stats_br_rst",   br_count_o,   32'd0);
      check_eq("stats_miss_rst", miss_count_o, 32'd0);
      reset_n = 1'b1;
`endif

      step();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
